// File: rtl/key_input_conditioner_pkg.sv
// rtl/key_input_conditioner_pkg.sv - shared key indices, digit limit and debounce state encoding
//
// Purpose: constants and helpers shared by key_debounce and key_input_conditioner.
// Contents:
//   KEY_UP..KEY_SETUP  bit positions of each button in key_raw / key_level
//   DIGIT_MAX          largest decimal digit presented on A
//   db_state_t         per-key debounce FSM state encoding
//   digit_step()       wrapping up/down step of the decimal digit
package key_input_conditioner_pkg;

  localparam int KEY_UP      = 0;
  localparam int KEY_DOWN    = 1;
  localparam int KEY_CONFIRM = 2;
  localparam int KEY_SURE    = 3;
  localparam int KEY_FIRE    = 4;
  localparam int KEY_READY   = 5;
  localparam int KEY_WAIT    = 6;
  localparam int KEY_SETUP   = 7;

  localparam logic [3:0] DIGIT_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,
    CHK_HIGH  = 2'b01,
    IDLE_HIGH = 2'b10,
    CHK_LOW   = 2'b11
  } db_state_t;

  // Opposing steps in the same cycle cancel; out-of-range values snap back into 0..9.
  function automatic logic [3:0] digit_step(input logic [3:0] a, input logic up, input logic dn);
    logic [3:0] r;
    r = a;
    if (up && !dn) begin
      r = (a >= DIGIT_MAX) ? 4'd0 : a + 4'd1;
    end else if (dn && !up) begin
      r = (a == 4'd0 || a > DIGIT_MAX) ? DIGIT_MAX : a - 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/key_input_conditioner_debounce.sv
// rtl/key_input_conditioner_debounce.sv - per-key synchroniser, debounce FSM and rising-edge pulse
//
// Purpose: turns one asynchronous button level into a debounced level and a
// one-cycle pulse on each debounced press.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   key_raw    raw asynchronous button level
//   level      debounced level
//   rise       combinational rising edge of level (one cycle ahead of pulse)
//   pulse      registered one-cycle press pulse
module key_debounce
  import key_input_conditioner_pkg::*;
#(
  parameter logic [19:0] DB_CNT_MAX = 20'd1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic level,
  output logic rise,
  output logic pulse
);

  logic        sync1;
  logic        s;
  logic        level_q;
  logic [19:0] cnt;
  logic        expire;
  db_state_t   state;

  assign expire = (cnt == DB_CNT_MAX - 20'd1);
  assign level  = (state == IDLE_HIGH) || (state == CHK_LOW);
  assign rise   = level & ~level_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      s       <= 1'b0;
      level_q <= 1'b0;
      pulse   <= 1'b0;
      cnt     <= '0;
      state   <= IDLE_LOW;
    end else begin
      sync1   <= key_raw;
      s       <= sync1;
      level_q <= level;
      pulse   <= rise;
      // The counter counts consecutive cycles of s disagreeing with level;
      // IDLE states also accept on the first mismatch when DB_CNT_MAX is 1.
      case (state)
        IDLE_LOW: begin
          if (s) begin
            if (expire) begin
              state <= IDLE_HIGH;
              cnt   <= '0;
            end else begin
              state <= CHK_HIGH;
              cnt   <= cnt + 20'd1;
            end
          end
        end
        CHK_HIGH: begin
          if (!s) begin
            state <= IDLE_LOW;
            cnt   <= '0;
          end else if (expire) begin
            state <= IDLE_HIGH;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 20'd1;
          end
        end
        IDLE_HIGH: begin
          if (!s) begin
            if (expire) begin
              state <= IDLE_LOW;
              cnt   <= '0;
            end else begin
              state <= CHK_LOW;
              cnt   <= cnt + 20'd1;
            end
          end
        end
        CHK_LOW: begin
          if (s) begin
            state <= IDLE_HIGH;
            cnt   <= '0;
          end else if (expire) begin
            state <= IDLE_LOW;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 20'd1;
          end
        end
        default: begin
          state <= IDLE_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_input_conditioner.sv
// rtl/key_input_conditioner.sv - debounced push-button front end producing command pulses and digit A
//
// Purpose: debounces eight buttons, emits one-cycle command pulses and keeps
// the decimal digit under entry. Optional auto-repeat of up/down while held is
// enabled by defining KEY_AUTOREPEAT_EN.
// Ports:
//   clk, rst                                   clock, synchronous active-high reset
//   key_raw[7:0]                               raw buttons (up, down, confirm, sure, fire, ready, wait_t, setup)
//   A[3:0]                                     current digit 0..9
//   confirm, sure, fire, ready, wait_t, setup  one-cycle command pulses
//   key_level[7:0]                             debounced levels
module key_input_conditioner
  import key_input_conditioner_pkg::*;
#(
  parameter logic [19:0] DB_CNT_MAX = 20'd1_000_000
`ifdef KEY_AUTOREPEAT_EN
  ,
  parameter logic [25:0] REP_DELAY  = 26'd25_000_000,
  parameter logic [25:0] REP_PERIOD = 26'd5_000_000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key_raw,
  output logic [3:0] A,
  output logic       confirm,
  output logic       sure,
  output logic       fire,
  output logic       ready,
  output logic       wait_t,
  output logic       setup,
  output logic [7:0] key_level
);

  localparam logic [7:0] CLR_MASK = (8'd1 << KEY_WAIT) | (8'd1 << KEY_SETUP);

  logic [7:0] level;
  logic [7:0] rise;
  logic [7:0] pulse;
  logic       up_step;
  logic       dn_step;
  logic       clr;

  for (genvar g = 0; g < 8; g++) begin : g_key
    key_debounce #(
      .DB_CNT_MAX(DB_CNT_MAX)
    ) u_debounce (
      .clk    (clk),
      .rst    (rst),
      .key_raw(key_raw[g]),
      .level  (level[g]),
      .rise   (rise[g]),
      .pulse  (pulse[g])
    );
  end

`ifdef KEY_AUTOREPEAT_EN
  logic [25:0] hold_cnt;
  logic        rep_step;
  logic        rep_up;
  logic        up_q;
  logic        dn_q;
  logic        excl;
  logic        swap;

  assign excl = level[KEY_UP] ^ level[KEY_DOWN];
  // Both levels flipping while still exclusive means a direct up<->down swap:
  // restart the hold as a fresh press of the other key.
  assign swap = (level[KEY_UP] != up_q) && (level[KEY_DOWN] != dn_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
      rep_step <= 1'b0;
      rep_up   <= 1'b0;
      up_q     <= 1'b0;
      dn_q     <= 1'b0;
    end else begin
      up_q   <= level[KEY_UP];
      dn_q   <= level[KEY_DOWN];
      rep_up <= level[KEY_UP];
      if (!excl) begin
        hold_cnt <= '0;
        rep_step <= 1'b0;
      end else if (swap) begin
        hold_cnt <= 26'd1;
        rep_step <= 1'b0;
      end else if (hold_cnt == REP_DELAY) begin
        // Reload so the next match is exactly REP_PERIOD cycles away.
        hold_cnt <= REP_DELAY - REP_PERIOD + 26'd1;
        rep_step <= 1'b1;
      end else begin
        hold_cnt <= hold_cnt + 26'd1;
        rep_step <= 1'b0;
      end
    end
  end

  assign up_step = pulse[KEY_UP]   | (rep_step & rep_up);
  assign dn_step = pulse[KEY_DOWN] | (rep_step & ~rep_up);
`else
  assign up_step = pulse[KEY_UP];
  assign dn_step = pulse[KEY_DOWN];
`endif

  // Clearing on the rise makes A read 0 in the same cycle as the wait_t/setup
  // pulse; clearing again on the pulse discards any step landing in that cycle.
  assign clr = (|(rise & CLR_MASK)) | (|(pulse & CLR_MASK));

  always_ff @(posedge clk) begin
    if (rst) begin
      A <= 4'd0;
    end else if (clr) begin
      A <= 4'd0;
    end else begin
      A <= digit_step(A, up_step, dn_step);
    end
  end

  assign confirm   = pulse[KEY_CONFIRM];
  assign sure      = pulse[KEY_SURE];
  assign fire      = pulse[KEY_FIRE];
  assign ready     = pulse[KEY_READY];
  assign wait_t    = pulse[KEY_WAIT];
  assign setup     = pulse[KEY_SETUP];
  assign key_level = level;

endmodule
